// File: rtl/ps2_key_transmitter.sv
// ps2_key_transmitter
//   Device-side PS/2 keyboard transmitter. Turns ps2_key events into
//   scan-code set 2 byte sequences, buffers them in a FIFO and serialises
//   them onto an open-collector PS/2 clock/data pair. It honours host
//   inhibit and answers host-to-device commands via a 3-byte response queue.
// Ports:
//   clk_sys      system clock
//   reset_n      asynchronous active-low reset
//   ps2_key      [10] toggle strobe, [9] pressed, [8] extended, [7:0] code
//   ps2_clk_in   sensed bus clock (wired-AND of both ends)
//   ps2_data_in  sensed bus data
//   ps2_clk_out  0 drives the bus clock low, 1 releases it
//   ps2_data_out 0 drives the bus data low, 1 releases it
//   busy         a TX or RX frame is in progress
//   overflow     one-cycle pulse when a key event is dropped
module ps2_key_transmitter #(
    parameter int CLK_DIV    = 1146,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic        ps2_clk_out,
    output logic        ps2_data_out,
    output logic        busy,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(2 * CLK_DIV) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, GAP, TX_HI, TX_LO, RX_REQ, RX_HI, RX_LO, RX_ACK
    } state_t;

    state_t state, state_nxt;

    logic          ref_valid, key_ref, ev_pend;
    logic [9:0]    ev_key;
    logic [1:0]    ev_len;
    logic [2:0][7:0] ev_b;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt, fifo_free;
    logic          push_ok, ovf_now, fifo_pop, flush;
    logic [2:0][7:0] rsp_q;
    logic [1:0]    rsp_cnt;
    logic [7:0]    tx_byte, last_sent, head_byte;
    logic          tx_src_rsp, pending, frame_bit;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [9:0]    rx_bits;
    logic          rx_ok;
    logic          tx_load, tx_done, rx_sample, rx_done, gap_restart, bit_inc;

    // Event capture: the first cycle after reset only learns the strobe level.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ref_valid <= 1'b0;
            key_ref   <= 1'b0;
            ev_pend   <= 1'b0;
            ev_key    <= '0;
        end else begin
            ev_pend <= 1'b0;
            if (!ref_valid) begin
                ref_valid <= 1'b1;
                key_ref   <= ps2_key[10];
            end else if (ps2_key[10] != key_ref) begin
                key_ref <= ps2_key[10];
                ev_pend <= 1'b1;
                ev_key  <= ps2_key[9:0];
            end
        end
    end

    // Byte sequence for the captured event; ev_b[0] is pushed first.
    always_comb begin
        ev_len = 2'd1 + {1'b0, ev_key[8]} + {1'b0, ~ev_key[9]};
        case ({ev_key[8], ev_key[9]})
            2'b10:   ev_b = {ev_key[7:0], 8'hF0, 8'hE0};
            2'b11:   ev_b = {8'h00, ev_key[7:0], 8'hE0};
            2'b00:   ev_b = {8'h00, ev_key[7:0], 8'hF0};
            default: ev_b = {8'h00, 8'h00, ev_key[7:0]};
        endcase
    end

    // Free space is taken before any same-cycle pop; a flush swallows the event.
    assign fifo_free = (AW+1)'(FIFO_DEPTH) - fifo_cnt;
    assign push_ok   = ev_pend && !flush && (fifo_free >= (AW+1)'(ev_len));
    assign ovf_now   = ev_pend && !flush && (fifo_free <  (AW+1)'(ev_len));
    assign fifo_pop  = tx_done && !tx_src_rsp;
    assign head_byte = (rsp_cnt != 2'd0) ? rsp_q[0] : fifo_mem[rd_ptr];
    assign pending   = (rsp_cnt != 2'd0) || (fifo_cnt != '0);

    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= ev_b[0];
            if (ev_len >= 2'd2) fifo_mem[wr_ptr + AW'(1)] <= ev_b[1];
            if (ev_len == 2'd3) fifo_mem[wr_ptr + AW'(2)] <= ev_b[2];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= ovf_now;
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                wr_ptr   <= wr_ptr + (push_ok ? AW'(ev_len) : '0);
                rd_ptr   <= rd_ptr + AW'(fifo_pop);
                fifo_cnt <= fifo_cnt + (push_ok ? (AW+1)'(ev_len) : '0)
                                     - (AW+1)'(fifo_pop);
            end
        end
    end

    // Host command decode, evaluated when the RX frame finishes.
    assign rx_ok = (^rx_bits[8:0]) && rx_bits[9];
    assign flush = rx_done && rx_ok && (rx_bits[7:0] == 8'hFF);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rsp_q      <= '0;
            rsp_cnt    <= 2'd0;
            tx_byte    <= '0;
            tx_src_rsp <= 1'b0;
            last_sent  <= '0;
        end else begin
            if (tx_load) begin
                tx_byte    <= head_byte;
                tx_src_rsp <= (rsp_cnt != 2'd0);
            end
            if (tx_done) begin
                last_sent <= tx_byte;
                if (tx_src_rsp) begin
                    rsp_q   <= {8'h00, rsp_q[2], rsp_q[1]};
                    rsp_cnt <= rsp_cnt - 2'd1;
                end
            end
            if (rx_done) begin
                if (!rx_ok) begin
                    rsp_q <= {16'h0000, 8'hFE};           rsp_cnt <= 2'd1;
                end else begin
                    case (rx_bits[7:0])
                        8'hFF: begin rsp_q <= {8'h00, 8'hAA, 8'hFA}; rsp_cnt <= 2'd2; end
                        8'hEE: begin rsp_q <= {16'h0000, 8'hEE};     rsp_cnt <= 2'd1; end
                        8'hF2: begin rsp_q <= {8'h83, 8'hAB, 8'hFA}; rsp_cnt <= 2'd3; end
                        8'hFE: begin rsp_q <= {16'h0000, last_sent}; rsp_cnt <= 2'd1; end
                        default: begin rsp_q <= {16'h0000, 8'hFA};   rsp_cnt <= 2'd1; end
                    endcase
                end
            end
        end
    end

    // Bit 0 start, 1..8 data LSB first, 9 odd parity, 10 stop.
    always_comb begin
        case (bit_idx)
            4'd0:    frame_bit = 1'b0;
            4'd9:    frame_bit = ~^tx_byte;
            4'd10:   frame_bit = 1'b1;
            default: frame_bit = tx_byte[3'(bit_idx - 4'd1)];
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        tx_load      = 1'b0;
        tx_done      = 1'b0;
        rx_sample    = 1'b0;
        rx_done      = 1'b0;
        gap_restart  = 1'b0;
        bit_inc      = 1'b0;
        ps2_clk_out  = 1'b1;
        ps2_data_out = 1'b1;
        case (state)
            IDLE: begin
                if (ps2_clk_in && !ps2_data_in)                  state_nxt = RX_REQ;
                else if (pending && ps2_clk_in && ps2_data_in)   state_nxt = GAP;
            end
            GAP: begin
                if (!ps2_clk_in)       gap_restart = 1'b1;
                else if (!ps2_data_in) state_nxt = IDLE;   // host RTS takes priority
                else if (cnt == GAP_LAST) begin
                    tx_load   = 1'b1;
                    state_nxt = TX_HI;
                end
            end
            TX_HI: begin
                ps2_data_out = frame_bit;
                if (!ps2_clk_in) begin
                    // Inhibit on the stop bit still counts as a delivered byte.
                    tx_done   = (bit_idx == 4'd10);
                    state_nxt = IDLE;
                end else if (cnt == HALF_LAST) begin
                    state_nxt = TX_LO;
                end
            end
            TX_LO: begin
                ps2_clk_out  = 1'b0;
                ps2_data_out = frame_bit;
                if (cnt == HALF_LAST) begin
                    if (bit_idx == 4'd10) begin
                        tx_done   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        bit_inc   = 1'b1;
                        state_nxt = TX_HI;
                    end
                end
            end
            RX_REQ: if (cnt == HALF_LAST) state_nxt = RX_LO;
            RX_LO: begin
                ps2_clk_out = 1'b0;
                if (cnt == HALF_LAST) state_nxt = RX_HI;
            end
            RX_HI: begin
                if (cnt == HALF_LAST) begin
                    rx_sample = 1'b1;
                    bit_inc   = 1'b1;
                    state_nxt = (bit_idx == 4'd9) ? RX_ACK : RX_LO;
                end
            end
            RX_ACK: begin
                ps2_data_out = 1'b0;
                ps2_clk_out  = (cnt > HALF_LAST);
                if (cnt == GAP_LAST) begin
                    rx_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE) && (state != GAP);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            rx_bits <= '0;
        end else begin
            cnt <= ((state_nxt != state) || gap_restart) ? '0 : cnt + CW'(1);
            if (state == IDLE) bit_idx <= '0;
            else if (bit_inc)  bit_idx <= bit_idx + 4'd1;
            if (rx_sample) rx_bits[bit_idx] <= ps2_data_in;
        end
    end

endmodule

// File: tb/tb_ps2_key_transmitter.sv
module tb_ps2_key_transmitter;

    localparam int CLK_DIV = 8;
    localparam int DEPTH   = 16;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic        ps2_clk_in, ps2_data_in;
    logic        ps2_clk_out, ps2_data_out, busy, overflow;
    logic        host_clk, host_data;
    bit          host_busy;

    assign ps2_clk_in  = ps2_clk_out  & host_clk;
    assign ps2_data_in = ps2_data_out & host_data;

    ps2_key_transmitter #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_key     (ps2_key),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_out (ps2_clk_out),
        .ps2_data_out(ps2_data_out),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    // Device-to-host frame monitor: latches data on each device clock fall.
    int          mon_bits = 0;
    logic [10:0] mon_frame;
    logic [10:0] last_frame = '0;
    longint      cyc = 0, first_fall = 0, prev_last_fall = 0, last_span = 0;
    bit          have_prev = 0;
    logic        prev_clk_out = 1'b1;

    always @(negedge clk_sys) begin
        logic [7:0] got, want;
        cyc++;
        if (host_busy || !reset_n) begin
            mon_bits = 0;
        end else if (prev_clk_out && !ps2_clk_out) begin
            if (mon_bits == 0) first_fall = cyc;
            mon_frame[mon_bits] = ps2_data_out;
            mon_bits++;
            if (mon_bits == 11) begin
                mon_bits   = 0;
                last_frame = mon_frame;
                last_span  = cyc - first_fall;
                got        = mon_frame[8:1];
                total++;
                if (mon_frame[0] !== 1'b0 || mon_frame[10] !== 1'b1 || (^mon_frame[9:1]) !== 1'b1) begin
                    bad++;
                    $display("FAIL framing: got frame %b, want start 0, odd parity, stop 1", mon_frame);
                end
                total++;
                if (last_span != 20 * CLK_DIV) begin
                    bad++;
                    $display("FAIL frame_span: got %0d, want %0d", last_span, 20 * CLK_DIV);
                end
                if (have_prev) begin
                    total++;
                    if (first_fall - prev_last_fall < 4 * CLK_DIV) begin
                        bad++;
                        $display("FAIL idle_gap: got fall-to-fall %0d, want >= %0d",
                                 first_fall - prev_last_fall, 4 * CLK_DIV);
                    end
                end
                have_prev      = 1;
                prev_last_fall = cyc;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_frame: got byte %h, want none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        bad++;
                        $display("FAIL tx_byte: got %h, want %h", got, want);
                    end
                end
            end
        end
        prev_clk_out = ps2_clk_out;
    end

    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic send_key(input logic ext, input logic pressed, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
        tick();
    endtask

    task automatic drain(input string name);
        int n = 0;
        int budget = exp_q.size() * 40 * CLK_DIV + 200;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: got %0d bytes still pending, want 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4 * CLK_DIV) tick();
    endtask

    task automatic wait_fall(output bit ok);
        logic prev = ps2_clk_out;
        ok = 0;
        for (int n = 0; n < 6 * CLK_DIV; n++) begin
            tick();
            if (prev && !ps2_clk_out) begin
                ok = 1;
                break;
            end
            prev = ps2_clk_out;
        end
    endtask

    // Host-to-device byte: inhibit, request-to-send, then data on each device clock low.
    task automatic host_send(input logic [7:0] b, input bit bad_par);
        logic [9:0] bits;
        bit ok = 1;
        int n = 0;
        bits = {1'b1, (~^b) ^ bad_par, b};
        host_busy = 1;
        host_clk  = 1'b0;
        repeat (2 * CLK_DIV) tick();
        host_data = 1'b0;
        tick();
        host_clk = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_fall(ok);
            if (!ok) break;
            host_data = bits[k];
        end
        while (ok && ps2_data_out !== 1'b0 && n < 4 * CLK_DIV) begin
            tick();
            n++;
        end
        chk("host_ack_low", {31'b0, ok && ps2_data_out === 1'b0}, 32'd1);
        n = 0;
        while (ps2_data_out === 1'b0 && n < 4 * CLK_DIV) begin
            tick();
            n++;
        end
        host_data = 1'b1;
        host_busy = 0;
    endtask

    typedef struct {
        logic        ext;
        logic        pressed;
        logic [7:0]  code;
        int          n;
        logic [23:0] bytes;   // first byte in [23:16]
    } key_vec_t;

    typedef struct {
        logic [7:0]  cmd;
        bit          bad_par;
        int          n;
        logic [23:0] bytes;
    } cmd_vec_t;

    key_vec_t kv[4];
    cmd_vec_t cv[5];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovf_cnt;
        int busy_seen;
        int n;

        kv[0] = '{1'b0, 1'b1, 8'h1C, 1, 24'h1C0000};
        kv[1] = '{1'b1, 1'b0, 8'h75, 3, 24'hE0F075};
        kv[2] = '{1'b0, 1'b0, 8'h1C, 2, 24'hF01C00};
        kv[3] = '{1'b1, 1'b1, 8'h6B, 2, 24'hE06B00};

        cv[0] = '{8'hEE, 1'b0, 1, 24'hEE0000};
        cv[1] = '{8'hF2, 1'b0, 3, 24'hFAAB83};
        cv[2] = '{8'hED, 1'b1, 1, 24'hFE0000};
        cv[3] = '{8'hFE, 1'b0, 1, 24'hFE0000};
        cv[4] = '{8'h55, 1'b0, 1, 24'hFA0000};

        reset_n   = 1'b0;
        ps2_key   = '0;
        host_clk  = 1'b1;
        host_data = 1'b1;
        host_busy = 0;
        repeat (3) tick();
        chk("reset_clk_out",  {31'b0, ps2_clk_out},  32'd1);
        chk("reset_data_out", {31'b0, ps2_data_out}, 32'd1);
        chk("reset_busy",     {31'b0, busy},         32'd0);
        chk("reset_overflow", {31'b0, overflow},     32'd0);
        reset_n = 1'b1;
        repeat (4) tick();

        // Key events on an idle bus.
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < kv[i].n; k++) exp_q.push_back(kv[i].bytes[23 - 8 * k -: 8]);
            send_key(kv[i].ext, kv[i].pressed, kv[i].code);
            drain("key_drain");
            if (i == 0) begin
                chk("frame_1C_bits", {21'b0, last_frame}, 32'h438);
                chk("frame_1C_span", last_span[31:0], 32'(20 * CLK_DIV));
            end
        end

        // Host inhibit during bit 4 of 1C: abort, then full resend.
        exp_q.push_back(8'h1C);
        send_key(1'b0, 1'b1, 8'h1C);
        n = 0;
        while (!(mon_bits == 4 && ps2_clk_out === 1'b1) && n < 40 * CLK_DIV) begin
            tick();
            n++;
        end
        chk("inhibit_reached_bit4", {31'b0, mon_bits == 4 && ps2_clk_out === 1'b1}, 32'd1);
        host_busy = 1;
        host_clk  = 1'b0;
        tick();
        chk("inhibit_clk_released",  {31'b0, ps2_clk_out},  32'd1);
        chk("inhibit_data_released", {31'b0, ps2_data_out}, 32'd1);
        chk("inhibit_not_busy",      {31'b0, busy},         32'd0);
        repeat (5 * CLK_DIV) tick();
        host_clk  = 1'b1;
        host_busy = 0;
        drain("inhibit_resend");

        // FF: pending FIFO byte is flushed, FA AA answered.
        host_busy = 1;
        host_clk  = 1'b0;
        send_key(1'b0, 1'b1, 8'h1C);
        repeat (4) tick();
        exp_q.push_back(8'hFA);
        exp_q.push_back(8'hAA);
        host_send(8'hFF, 1'b0);
        drain("reset_cmd_drain");
        repeat (40 * CLK_DIV) tick();

        // Other host commands, including a parity error and a resend.
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < cv[i].n; k++) exp_q.push_back(cv[i].bytes[23 - 8 * k -: 8]);
            host_send(cv[i].cmd, cv[i].bad_par);
            drain("cmd_drain");
        end

        // FIFO full: 8 two-byte events fit, the 9th drops whole with one pulse.
        host_busy = 1;
        host_clk  = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                exp_q.push_back(8'hE0);
                exp_q.push_back(8'h10 + 8'(i));
            end
            send_key(1'b1, 1'b1, 8'h10 + 8'(i));
            ovf_cnt = 0;
            repeat (4) begin
                if (overflow === 1'b1) ovf_cnt++;
                tick();
            end
            chk("overflow_pulses", ovf_cnt, (i == 8) ? 32'd1 : 32'd0);
        end
        host_clk  = 1'b1;
        host_busy = 0;
        drain("fifo_full_drain");
        repeat (40 * CLK_DIV) tick();

        // Asynchronous reset mid-frame, with a strobe change while in reset.
        exp_q.push_back(8'h1C);
        send_key(1'b0, 1'b1, 8'h1C);
        n = 0;
        while (mon_bits < 3 && n < 40 * CLK_DIV) begin
            tick();
            n++;
        end
        host_busy = 1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_clk_out",  {31'b0, ps2_clk_out},  32'd1);
        chk("async_reset_data_out", {31'b0, ps2_data_out}, 32'd1);
        chk("async_reset_busy",     {31'b0, busy},         32'd0);
        exp_q.delete();
        ps2_key[10] = ~ps2_key[10];
        repeat (2) tick();
        reset_n   = 1'b1;
        host_busy = 0;
        busy_seen = 0;
        repeat (40 * CLK_DIV) begin
            tick();
            if (busy === 1'b1) busy_seen++;
        end
        chk("no_event_after_reset", busy_seen, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
